vector_accumulator: RTL and testbench
=====================================

VECTOR_ACCUMULATOR -- requirements
Module: vector_accumulator

Interface
REQ-001 Parameter LOG2_N, default 3, sets the window length: N = 2^LOG2_N samples per average; legal range 0..8.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 s_valid  input  1  sample present on s_x/s_y/s_z.
REQ-005 s_ready  output  1  block can accept a sample this cycle.
REQ-006 s_x, s_y, s_z  input  32 each  signed Q16.16 sample components.
REQ-007 flush  input  1  discard the partial window.
REQ-008 vx, vy, vz  output  32 each  signed Q16.16 window average, to the normalizer.
REQ-009 start  output  1  one-cycle launch pulse to the normalizer.
REQ-010 norm_busy  input  1  normalizer busy flag.
REQ-011 windows_done  output  16  count of windows handed off, wrapping.

Function
REQ-012 A sample transfers when s_valid and s_ready are both 1 on a rising clk edge.
REQ-013 Each transferred sample adds into three signed accumulators of width 32+LOG2_N; the accumulators never overflow.
REQ-014 sample_cnt (LOG2_N+1 bits) counts the transfers in the current window.
REQ-015 On the transfer that makes sample_cnt = N, the block SHALL form the window average as acc >>> LOG2_N (arithmetic shift, truncation toward minus infinity) using the accumulator value that includes that sample.
REQ-016 If the holding register is empty, the average goes to the holding register on that same edge; the accumulators and counter clear.
REQ-017 If the holding register is full, the completed window stays in the accumulators and s_ready = 0 until the holding register empties.
REQ-018 While a completed window is pending, s_ready = 0 and the window transfers to the holding register on the edge the holding register frees.
REQ-019 Outside the REQ-017/018 stall, s_ready = 1.
REQ-020 vx/vy/vz are driven directly from the holding register.
REQ-021 vx/vy/vz SHALL stay constant from the start pulse until the hand-off completes.
REQ-022 Hand-off FSM states are O_EMPTY, O_START, O_ACK, O_RUN.
REQ-023 O_EMPTY -> O_START when the holding register is loaded.
REQ-024 O_START: start = 1 for exactly one cycle, then -> O_ACK.
REQ-025 O_ACK: wait for norm_busy = 1, then -> O_RUN.
REQ-026 O_RUN: wait for norm_busy = 0; on that edge the holding register frees, windows_done increments, and the FSM -> O_EMPTY.
REQ-027 In O_RUN with a completed window pending, the FSM goes O_RUN -> O_START with the new window loaded on the same edge; no idle cycle is inserted.
REQ-028 start = 0 in every state except O_START.
REQ-029 The first start of a new hand-off occurs 1 cycle after the holding register loads.
REQ-030 flush (REQ-031/032) clears only the accumulators and sample_cnt; it SHALL NOT disturb the holding register or the hand-off FSM.
REQ-031 flush with a transfer on the same edge: the accumulators load that sample alone and sample_cnt = 1.
REQ-032 flush with no transfer: the accumulators clear, sample_cnt = 0, and a pending completed window is discarded.
REQ-033 windows_done wraps 0xFFFF -> 0x0000.
REQ-034 With LOG2_N = 0, every sample is its own window and the average equals the sample.

Reset
REQ-035 rst clears every output, accumulator and counter to 0, puts the FSM in O_EMPTY, and sets s_ready = 1 from the first clock edge after deassertion.
REQ-036 Reset asserted mid-window or mid-hand-off abandons all data; no start pulse is issued for the abandoned data.

Structure
REQ-037 A shared package holds the Q16.16 width constant (32), the FRAC_BITS constant (16) and the hand-off state encoding.
REQ-038 One sub-module, vec_acc_lane, is instantiated three times; it holds one component's accumulator, clear/flush logic and the shifted average.
REQ-039 sample_cnt and the FSM live in the top level.

Verification
REQ-040 LOG2_N = 3, eight samples of (0x00010000, 0xFFFF0000, 0x00020000), norm_busy model high for 6 cycles -> vx/vy/vz = 0x00010000/0xFFFF0000/0x00020000, a single start pulse, windows_done = 1.
REQ-041 LOG2_N = 2, x samples 1, 2, 3, -7 (raw LSBs) -> vx = 0xFFFFFFFF, i.e. -1 by arithmetic shift.
REQ-042 Continuous s_valid with norm_busy held high for 100 cycles -> second window completes, then s_ready = 0; no data is lost; a back-to-back start follows 1 cycle after norm_busy falls.
REQ-043 flush after 5 of 8 samples, then 8 samples of 0x00030000 -> vx = 0x00030000.
REQ-044 rst pulsed during O_ACK -> start never re-pulses, all outputs = 0, windows_done = 0.
REQ-045 Extreme inputs: 8 samples of 0x7FFFFFFF -> vx = 0x7FFFFFFF; 8 samples of 0x80000000 -> vx = 0x80000000.

Source files
------------

// File: rtl/vector_accumulator_pkg.sv
// rtl/vector_accumulator_pkg.sv - shared Q16.16 widths and hand-off state encoding
package vector_accumulator_pkg;

  localparam int Q_W       = 32;
  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {
    O_EMPTY = 2'd0,
    O_START = 2'd1,
    O_ACK   = 2'd2,
    O_RUN   = 2'd3
  } ho_state_e;

endpackage

// File: rtl/vec_acc_lane.sv
// rtl/vec_acc_lane.sv - one vector component: widened accumulator and shifted window average
module vec_acc_lane
  import vector_accumulator_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           add_i,
  input  logic           flush_i,
  input  logic           clear_i,
  input  logic [Q_W-1:0] sample_i,
  output logic [Q_W-1:0] avg_o
);

  localparam int AW = Q_W + LOG2_N;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] sample_ext;

  assign sample_ext = AW'($signed(sample_i));

  always_comb begin
    acc_d = flush_i ? '0 : acc_q;
    if (add_i) begin
      acc_d = acc_d + sample_ext;
    end
  end

  // avg_o reflects the sum including this cycle's sample, so a completing
  // window and a pending one both hand off from the same path
  assign avg_o = Q_W'(acc_d >>> LOG2_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/vector_accumulator.sv
// rtl/vector_accumulator.sv - windowed 3-component average with single-entry hand-off to a normalizer
module vector_accumulator
  import vector_accumulator_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [Q_W-1:0] s_x,
  input  logic [Q_W-1:0] s_y,
  input  logic [Q_W-1:0] s_z,
  input  logic           flush,
  output logic [Q_W-1:0] vx,
  output logic [Q_W-1:0] vy,
  output logic [Q_W-1:0] vz,
  output logic           start,
  input  logic           norm_busy,
  output logic [15:0]    windows_done
);

  localparam int            CW    = LOG2_N + 1;
  localparam logic [CW-1:0] N_CNT = CW'(1 << LOG2_N);

  ho_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    done_q, done_d;
  logic [Q_W-1:0] hold_x_q, hold_y_q, hold_z_q;
  logic [Q_W-1:0] avg_x, avg_y, avg_z;

  logic          xfer;
  logic          pending;
  logic          complete_now;
  logic          hold_free;
  logic          hold_avail;
  logic          load;
  logic [CW-1:0] cnt_inc;

  // a full count means a completed window is parked in the accumulators
  assign pending      = (cnt_q == N_CNT);
  assign s_ready      = ~pending;
  assign xfer         = s_valid & s_ready;
  assign cnt_inc      = flush ? CW'(1) : cnt_q + CW'(1);
  assign complete_now = xfer & (cnt_inc == N_CNT);
  assign hold_free    = (state_q == O_RUN) & ~norm_busy;
  assign hold_avail   = (state_q == O_EMPTY) | hold_free;
  assign load         = hold_avail & (complete_now | (pending & ~flush));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (flush) begin
      cnt_d = xfer ? CW'(1) : '0;
    end else if (xfer) begin
      cnt_d = cnt_inc;
    end
  end

  vec_acc_lane #(.LOG2_N(LOG2_N)) u_lane_x (
    .clk(clk), .rst(rst), .add_i(xfer), .flush_i(flush), .clear_i(load),
    .sample_i(s_x), .avg_o(avg_x)
  );

  vec_acc_lane #(.LOG2_N(LOG2_N)) u_lane_y (
    .clk(clk), .rst(rst), .add_i(xfer), .flush_i(flush), .clear_i(load),
    .sample_i(s_y), .avg_o(avg_y)
  );

  vec_acc_lane #(.LOG2_N(LOG2_N)) u_lane_z (
    .clk(clk), .rst(rst), .add_i(xfer), .flush_i(flush), .clear_i(load),
    .sample_i(s_z), .avg_o(avg_z)
  );

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    start   = 1'b0;
    unique case (state_q)
      O_EMPTY: begin
        if (load) state_d = O_START;
      end
      O_START: begin
        start   = 1'b1;
        state_d = O_ACK;
      end
      O_ACK: begin
        if (norm_busy) state_d = O_RUN;
      end
      O_RUN: begin
        if (!norm_busy) begin
          done_d  = done_q + 16'd1;
          state_d = load ? O_START : O_EMPTY;
        end
      end
      default: state_d = O_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= O_EMPTY;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_x_q <= '0;
      hold_y_q <= '0;
      hold_z_q <= '0;
    end else if (load) begin
      hold_x_q <= avg_x;
      hold_y_q <= avg_y;
      hold_z_q <= avg_z;
    end
  end

  assign vx           = hold_x_q;
  assign vy           = hold_y_q;
  assign vz           = hold_z_q;
  assign windows_done = done_q;

endmodule

// File: tb/tb_vector_accumulator.sv
// tb/tb_vector_accumulator.sv - scoreboard bench for vector_accumulator at LOG2_N 3, 2 and 0
`timescale 1ns/1ps
module tb_vector_accumulator;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid      [NI];
  logic        s_ready      [NI];
  logic [31:0] s_x          [NI];
  logic [31:0] s_y          [NI];
  logic [31:0] s_z          [NI];
  logic        flush        [NI];
  logic [31:0] vx           [NI];
  logic [31:0] vy           [NI];
  logic [31:0] vz           [NI];
  logic        start        [NI];
  logic        norm_busy    [NI];
  logic [15:0] windows_done [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          busy_len       [NI];
  int          ack_dly        [NI];
  int          done_cnt       [NI];
  int          start_cnt      [NI];
  int          last_start_cyc [NI];
  int          last_fall_cyc  [NI];
  logic [95:0] snap           [NI];
  logic [95:0] exp_q          [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // floor(sum / n): the window average rounded toward minus infinity
  function automatic logic [31:0] avg_of(longint s, int n);
    longint q;
    q = s / longint'(n);
    if ((s % longint'(n)) != 0 && s < 0) q = q - 1;
    return q[31:0];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LG = (g == 0) ? 3 : (g == 1) ? 2 : 0;
    localparam int NW = 1 << LG;

    longint      sx, sy, sz;
    int          wcnt;
    int          rphase, rcnt;
    logic [95:0] e;

    vector_accumulator #(.LOG2_N(LG)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[g]), .s_ready(s_ready[g]),
      .s_x(s_x[g]), .s_y(s_y[g]), .s_z(s_z[g]),
      .flush(flush[g]),
      .vx(vx[g]), .vy(vy[g]), .vz(vz[g]),
      .start(start[g]), .norm_busy(norm_busy[g]),
      .windows_done(windows_done[g])
    );

    always @(negedge clk) begin : model_mon
      if (rst) begin
        sx = 0; sy = 0; sz = 0; wcnt = 0;
        exp_q[g].delete();
        start_cnt[g] = 0;
      end else begin
        if (start[g]) begin
          start_cnt[g]++;
          last_start_cyc[g] = cyc;
          snap[g] = {vz[g], vy[g], vx[g]};
          if (exp_q[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL start_unexpected[%0d] actual=start required=no_start", g);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("avg_x[%0d]", g), vx[g], e[31:0]);
            check($sformatf("avg_y[%0d]", g), vy[g], e[63:32]);
            check($sformatf("avg_z[%0d]", g), vz[g], e[95:64]);
          end
        end
        if (flush[g]) begin
          // a completed window still waiting for the holding register is dropped
          if (!s_ready[g] && exp_q[g].size() != 0) void'(exp_q[g].pop_back());
          sx = 0; sy = 0; sz = 0; wcnt = 0;
        end
        if (s_valid[g] && s_ready[g]) begin
          sx += longint'($signed(s_x[g]));
          sy += longint'($signed(s_y[g]));
          sz += longint'($signed(s_z[g]));
          wcnt++;
        end
        if (wcnt == NW) begin
          exp_q[g].push_back({avg_of(sz, NW), avg_of(sy, NW), avg_of(sx, NW)});
          sx = 0; sy = 0; sz = 0; wcnt = 0;
        end
      end
    end

    always @(negedge clk) begin : responder
      if (rst) begin
        norm_busy[g] = 1'b0;
        rphase = 0; rcnt = 0;
        done_cnt[g] = 0;
      end else begin
        case (rphase)
          0: if (start[g]) begin rphase = 1; rcnt = ack_dly[g]; end
          1: begin
            if (rcnt == 0) begin
              norm_busy[g] = 1'b1; rcnt = busy_len[g]; rphase = 2;
            end else rcnt--;
          end
          default: begin
            if (rcnt <= 1) begin
              norm_busy[g] = 1'b0;
              done_cnt[g]++;
              last_fall_cyc[g] = cyc;
              rphase = 0;
              check($sformatf("hold_stable_x[%0d]", g), vx[g], snap[g][31:0]);
              check($sformatf("hold_stable_y[%0d]", g), vy[g], snap[g][63:32]);
              check($sformatf("hold_stable_z[%0d]", g), vz[g], snap[g][95:64]);
            end else rcnt--;
          end
        endcase
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(int g, logic [31:0] x, logic [31:0] y, logic [31:0] z);
    bit acc;
    int t;
    s_valid[g] = 1'b1; s_x[g] = x; s_y[g] = y; s_z[g] = z;
    acc = 1'b0; t = 0;
    while (!acc && t < 2000) begin
      @(negedge clk); acc = s_ready[g];
      @(posedge clk); #1; t++;
    end
    s_valid[g] = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout[%0d] actual=stalled required=accepted", g);
    end
  endtask

  task automatic do_flush(int g);
    flush[g] = 1'b1;
    @(posedge clk); #1;
    flush[g] = 1'b0;
  endtask

  task automatic wait_done(int g, int target, string name);
    int t = 0;
    while (done_cnt[g] < target && t < 3000) begin @(posedge clk); #1; t++; end
    check(name, 32'(done_cnt[g]), 32'(target));
    idle(2);
  endtask

  task automatic rand_stim(int g, int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) do_flush(g);
      else if (r < 4) idle($urandom_range(1, 3));
      if (r == 5) begin
        busy_len[g] = $urandom_range(1, 12);
        ack_dly[g]  = $urandom_range(0, 3);
      end
      send(g, $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    int base;
    int t;
    logic [31:0] r;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      s_valid[g] = 1'b0; flush[g] = 1'b0;
      s_x[g] = '0; s_y[g] = '0; s_z[g] = '0;
      busy_len[g] = 3; ack_dly[g] = 1;
      last_start_cyc[g] = 0; last_fall_cyc[g] = 0; snap[g] = '0;
    end
    idle(3);
    rst = 1'b0;

    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_vx[%0d]", g), vx[g], 32'h0);
      check($sformatf("rst_vy[%0d]", g), vy[g], 32'h0);
      check($sformatf("rst_vz[%0d]", g), vz[g], 32'h0);
      check($sformatf("rst_start[%0d]", g), 32'(start[g]), 32'h0);
      check($sformatf("rst_wdone[%0d]", g), 32'(windows_done[g]), 32'h0);
      check($sformatf("rst_ready[%0d]", g), 32'(s_ready[g]), 32'h1);
    end
    @(posedge clk); #1;

    // unit-vector style window, one hand-off
    busy_len[0] = 6;
    base = start_cnt[0];
    repeat (8) send(0, 32'h00010000, 32'hFFFF0000, 32'h00020000);
    wait_done(0, 1, "win1_done");
    check("win1_vx", snap[0][31:0], 32'h00010000);
    check("win1_vy", snap[0][63:32], 32'hFFFF0000);
    check("win1_vz", snap[0][95:64], 32'h00020000);
    check("win1_starts", 32'(start_cnt[0] - base), 32'd1);
    check("win1_wdone", 32'(windows_done[0]), 32'd1);

    // negative sum rounds toward minus infinity
    send(1, 32'd1, $urandom, $urandom);
    send(1, 32'd2, $urandom, $urandom);
    send(1, 32'd3, $urandom, $urandom);
    send(1, 32'hFFFFFFF9, $urandom, $urandom);
    wait_done(1, 1, "neg_done");
    check("neg_vx", snap[1][31:0], 32'hFFFFFFFF);

    // partial window flushed away
    busy_len[0] = 2;
    repeat (5) send(0, $urandom, $urandom, $urandom);
    do_flush(0);
    repeat (8) send(0, 32'h00030000, 32'h00030000, 32'h00030000);
    wait_done(0, 2, "flush_done");
    check("flush_vx", snap[0][31:0], 32'h00030000);

    // extremes
    repeat (8) send(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done(0, 3, "max_done");
    check("max_vx", snap[0][31:0], 32'h7FFFFFFF);
    repeat (8) send(0, 32'h80000000, 32'h80000000, 32'h80000000);
    wait_done(0, 4, "min_done");
    check("min_vx", snap[0][31:0], 32'h80000000);

    // single-sample windows
    for (int k = 1; k <= 4; k++) begin
      r = $urandom;
      send(2, r, ~r, r ^ 32'h5A5A5A5A);
      wait_done(2, k, "n1_done");
      check("n1_vx", snap[2][31:0], r);
    end

    // long normalizer busy: stall after second window, back-to-back start
    busy_len[0] = 100;
    base = start_cnt[0];
    repeat (16) send(0, $urandom, $urandom, $urandom);
    @(negedge clk);
    check("stall_ready", 32'(s_ready[0]), 32'h0);
    @(posedge clk); #1;
    t = 0;
    while (start_cnt[0] < base + 2 && t < 1000) begin @(posedge clk); #1; t++; end
    check("b2b_started", 32'(start_cnt[0] - base), 32'd2);
    check("b2b_gap", 32'(last_start_cyc[0] - last_fall_cyc[0]), 32'd1);
    repeat (8) send(0, $urandom, $urandom, $urandom);
    wait_done(0, 7, "b2b_done");
    check("b2b_wdone", 32'(windows_done[0]), 32'd7);

    // randomized traffic on all three widths
    busy_len[0] = 4;
    fork
      rand_stim(0, 120);
      rand_stim(1, 80);
      rand_stim(2, 40);
    join
    for (int g = 0; g < NI; g++) begin
      t = 0;
      while ((exp_q[g].size() != 0 || done_cnt[g] != start_cnt[g]) && t < 5000) begin
        @(posedge clk); #1; t++;
      end
      idle(2);
      check($sformatf("drain[%0d]", g), 32'(exp_q[g].size()), 32'd0);
      check($sformatf("wdone[%0d]", g), 32'(windows_done[g]), 32'(16'(done_cnt[g])));
    end

    // reset while waiting for the normalizer to acknowledge
    ack_dly[0] = 20;
    busy_len[0] = 5;
    base = start_cnt[0];
    repeat (8) send(0, 32'h00050000, 32'h00050000, 32'h00050000);
    t = 0;
    while (start_cnt[0] < base + 1 && t < 100) begin @(posedge clk); #1; t++; end
    check("ack_started", 32'(start_cnt[0] - base), 32'd1);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack_vx", vx[0], 32'h0);
    check("rst_ack_vy", vy[0], 32'h0);
    check("rst_ack_vz", vz[0], 32'h0);
    check("rst_ack_wdone", 32'(windows_done[0]), 32'h0);
    @(posedge clk); #1;
    idle(40);
    check("rst_ack_nostart", 32'(start_cnt[0]), 32'd0);
    check("rst_ack_wdone2", 32'(windows_done[0]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
